// File: rtl/display_scan.sv
// Four-digit multiplexed hex display scanner with per-slot dead time,
// frame-aligned display updates and optional leading-zero blanking.
module display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_en,
    output logic [3:0]  digit,
    output logic        blank,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pend_q, pend_d;
    logic [15:0]      disp_q, disp_d;
    logic             lz_q;
    logic             run_q;

    logic cnt_wrap;
    logic frame_end;
    logic dead_time;
    logic lead_zero;
    logic in_blank;

    assign cnt_wrap  = (cnt_q == CNT_LAST);
    assign frame_end = cnt_wrap && (idx_q == 2'd3);

    // A load on the frame edge reaches disp through pend_d, giving the bypass.
    always_comb begin
        cnt_d  = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d  = cnt_wrap ? idx_q + 2'd1 : idx_q;
        pend_d = load ? value : pend_q;
        disp_d = frame_end ? pend_d : disp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            pend_q <= 16'h0000;
            disp_q <= 16'h0000;
            lz_q   <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            disp_q <= disp_d;
            lz_q   <= lz_en;
            run_q  <= 1'b1;
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign dead_time = 1'b0;
        end else begin : g_dead
            assign dead_time = (cnt_q < BLANK_END);
        end
    endgenerate

    always_comb begin
        digit     = 4'h0;
        lead_zero = 1'b0;
        case (idx_q)
            2'd0: digit = disp_q[3:0];
            2'd1: begin digit = disp_q[7:4];   lead_zero = (disp_q[15:4] == 12'h000); end
            2'd2: begin digit = disp_q[11:8];  lead_zero = (disp_q[15:8] == 8'h00);   end
            default: begin digit = disp_q[15:12]; lead_zero = (disp_q[15:12] == 4'h0); end
        endcase
    end

    // run_q keeps the anodes dark until the first edge after reset release.
    assign in_blank   = !run_q || dead_time || (lz_q && lead_zero);
    assign blank      = in_blank;
    assign an         = in_blank ? 4'b1111 : ~(4'b0001 << idx_q);
    assign frame_tick = frame_end;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=8, BLANK_CYC=2.
module tb_display_scan;
    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  digit;
    logic        blank;
    logic [3:0]  an;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;
    int ei = 0;
    int ec = 0;

    logic [3:0] ed [4];
    logic [3:0] lit;
    logic [3:0] ea;
    logic       eb;
    int         s;

    display_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .lz_en(lz_en),
        .digit(digit), .blank(blank), .an(an), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (ec == 7) begin
                ec = 0;
                ei = (ei + 1) % 4;
            end else begin
                ec++;
            end
        end
    endtask

    task automatic wait_for(input int wi, input int wc);
        int n = 0;
        while (!(ei == wi && ec == wc) && n < 200) begin
            tick();
            n++;
        end
        if (!(ei == wi && ec == wc)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_for timeout: at idx=%0d cnt=%0d, required idx=%0d cnt=%0d", ei, ec, wi, wc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load = 1'b0; value = 16'h0000; lz_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL por_an got %b want 1111", an); end
        if (blank !== 1'b1) begin miscompares++; $display("FAIL por_blank got %b want 1", blank); end
        if (digit !== 4'h0) begin miscompares++; $display("FAIL por_digit got %h want 0", digit); end
        if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL por_tick got %b want 0", frame_tick); end
        load = 1'b1; value = 16'hFFFF;
        repeat (3) tick();
        load = 1'b0; value = 16'h0000;
        rst_n = 1'b1; ei = 0; ec = 0;
        tick();
        vectors += 2;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL rel_cnt1_an got %b want 1111", an); end
        if (blank !== 1'b1) begin miscompares++; $display("FAIL rel_cnt1_blank got %b want 1", blank); end
        tick();
        vectors += 3;
        if (an !== 4'b1110) begin miscompares++; $display("FAIL rel_cnt2_an got %b want 1110", an); end
        if (blank !== 1'b0) begin miscompares++; $display("FAIL rel_cnt2_blank got %b want 0", blank); end
        if (digit !== 4'h0) begin miscompares++; $display("FAIL rel_cnt2_digit got %h want 0", digit); end
        // A load held during reset must not have reached pend.
        wait_for(1, 2);
        wait_for(0, 1);
        wait_for(1, 2);
        vectors++;
        if (digit !== 4'h0) begin miscompares++; $display("FAIL load_in_reset digit got %h want 0", digit); end
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0;
        wait_for(0, 1);
        wait_for(2, 5);
        vectors++;
        if (digit !== 4'h2) begin miscompares++; $display("FAIL pre_reset digit got %h want 2", digit); end
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL mid_an got %b want 1111", an); end
        if (blank !== 1'b1) begin miscompares++; $display("FAIL mid_blank got %b want 1", blank); end
        if (digit !== 4'h0) begin miscompares++; $display("FAIL mid_digit got %h want 0", digit); end
        if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL mid_tick got %b want 0", frame_tick); end
        repeat (2) tick();
        rst_n = 1'b1; ei = 0; ec = 0;
        tick();
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL mid_rel_cnt1_an got %b want 1111", an); end
        tick();
        vectors += 2;
        if (an !== 4'b1110) begin miscompares++; $display("FAIL mid_rel_cnt2_an got %b want 1110", an); end
        if (digit !== 4'h0) begin miscompares++; $display("FAIL mid_rel_cnt2_digit got %h want 0", digit); end
    endtask

    task automatic test_scan();
        wait_for(1, 0);
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0;
        wait_for(0, 0);
        ed = '{4'h4, 4'h3, 4'h2, 4'h1};
        lit = 4'b1111;
        for (int k = 0; k < 32; k++) begin
            s = ei;
            ea = 4'hF;
            if (lit[s] && ec >= 2) ea[s] = 1'b0;
            eb = (ea == 4'hF);
            vectors += 3;
            if (digit !== ed[s]) begin miscompares++; $display("FAIL scan_digit idx=%0d cnt=%0d got %h want %h", ei, ec, digit, ed[s]); end
            if (an !== ea) begin miscompares++; $display("FAIL scan_an idx=%0d cnt=%0d got %b want %b", ei, ec, an, ea); end
            if (blank !== eb) begin miscompares++; $display("FAIL scan_blank idx=%0d cnt=%0d got %b want %b", ei, ec, blank, eb); end
            tick();
        end
    endtask

    task automatic test_tear_free();
        int n = 0;
        wait_for(2, 3);
        load = 1'b1; value = 16'hABCD;
        tick();
        load = 1'b0;
        while (!(ei == 0 && ec == 0) && n < 40) begin
            ea = 4'hF;
            if (ec >= 2) ea[ei] = 1'b0;
            vectors += 2;
            if (digit !== ((ei == 2) ? 4'h2 : 4'h1)) begin miscompares++; $display("FAIL tear_old_digit idx=%0d cnt=%0d got %h want %h", ei, ec, digit, (ei == 2) ? 4'h2 : 4'h1); end
            if (an !== ea) begin miscompares++; $display("FAIL tear_old_an idx=%0d cnt=%0d got %b want %b", ei, ec, an, ea); end
            tick();
            n++;
        end
        ed = '{4'hD, 4'hC, 4'hB, 4'hA};
        for (int k = 0; k < 32; k++) begin
            s = ei;
            ea = 4'hF;
            if (ec >= 2) ea[s] = 1'b0;
            vectors += 2;
            if (digit !== ed[s]) begin miscompares++; $display("FAIL tear_new_digit idx=%0d cnt=%0d got %h want %h", ei, ec, digit, ed[s]); end
            if (an !== ea) begin miscompares++; $display("FAIL tear_new_an idx=%0d cnt=%0d got %b want %b", ei, ec, an, ea); end
            tick();
        end
    endtask

    task automatic test_bypass();
        wait_for(1, 0);
        load = 1'b1; value = 16'h1111;
        tick();
        load = 1'b0;
        wait_for(3, 7);
        load = 1'b1; value = 16'h5A5A;
        tick();
        load = 1'b0;
        ed = '{4'hA, 4'h5, 4'hA, 4'h5};
        for (int k = 0; k < 64; k++) begin
            s = ei;
            vectors++;
            if (digit !== ed[s]) begin miscompares++; $display("FAIL bypass_digit idx=%0d cnt=%0d got %h want %h", ei, ec, digit, ed[s]); end
            tick();
        end
    endtask

    task automatic test_lz();
        lz_en = 1'b1;
        wait_for(1, 0);
        load = 1'b1; value = 16'h0050;
        tick();
        load = 1'b0;
        wait_for(0, 0);
        ed = '{4'h0, 4'h5, 4'h0, 4'h0};
        lit = 4'b0011;
        for (int k = 0; k < 32; k++) begin
            s = ei;
            ea = 4'hF;
            if (lit[s] && ec >= 2) ea[s] = 1'b0;
            eb = (ea == 4'hF);
            vectors += 3;
            if (digit !== ed[s]) begin miscompares++; $display("FAIL lz50_digit idx=%0d cnt=%0d got %h want %h", ei, ec, digit, ed[s]); end
            if (an !== ea) begin miscompares++; $display("FAIL lz50_an idx=%0d cnt=%0d got %b want %b", ei, ec, an, ea); end
            if (blank !== eb) begin miscompares++; $display("FAIL lz50_blank idx=%0d cnt=%0d got %b want %b", ei, ec, blank, eb); end
            tick();
        end
        wait_for(1, 0);
        load = 1'b1; value = 16'h0000;
        tick();
        load = 1'b0;
        wait_for(0, 0);
        lit = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            s = ei;
            ea = 4'hF;
            if (lit[s] && ec >= 2) ea[s] = 1'b0;
            eb = (ea == 4'hF);
            vectors += 3;
            if (digit !== 4'h0) begin miscompares++; $display("FAIL lz0_digit idx=%0d cnt=%0d got %h want 0", ei, ec, digit); end
            if (an !== ea) begin miscompares++; $display("FAIL lz0_an idx=%0d cnt=%0d got %b want %b", ei, ec, an, ea); end
            if (blank !== eb) begin miscompares++; $display("FAIL lz0_blank idx=%0d cnt=%0d got %b want %b", ei, ec, blank, eb); end
            tick();
        end
        wait_for(2, 4);
        lz_en = 1'b0;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL lz_off_before an got %b want 1111", an); end
        tick();
        vectors += 2;
        if (an !== 4'b1011) begin miscompares++; $display("FAIL lz_off_after an got %b want 1011", an); end
        if (blank !== 1'b0) begin miscompares++; $display("FAIL lz_off_after blank got %b want 0", blank); end
    endtask

    task automatic test_frame_tick();
        int pulses = 0;
        int last_k = -1;
        logic et;
        wait_for(0, 0);
        for (int k = 0; k < 96; k++) begin
            et = (ei == 3 && ec == 7);
            vectors++;
            if (frame_tick !== et) begin miscompares++; $display("FAIL tick_level k=%0d idx=%0d cnt=%0d got %b want %b", k, ei, ec, frame_tick, et); end
            if (frame_tick === 1'b1) begin
                if (last_k >= 0) begin
                    vectors++;
                    if (k - last_k != 32) begin miscompares++; $display("FAIL tick_spacing got %0d want 32", k - last_k); end
                end
                last_k = k;
                pulses++;
            end
            tick();
        end
        vectors++;
        if (pulses != 3) begin miscompares++; $display("FAIL tick_count got %0d want 3", pulses); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_bypass();
        test_lz();
        test_frame_tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, giving clock cycles per digit slot; legal range is SCAN_DIV >= 2.
REQ-002 The module SHALL have parameter BLANK_CYC, default 16, giving dead-time cycles at the start of each slot; legal range is 0 <= BLANK_CYC < SCAN_DIV.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port load  input  1  SHALL be a write strobe; when high, value is captured on that rising edge.
REQ-006 Port value  input  16  SHALL carry four hex nibbles: [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-007 Port lz_en  input  1  SHALL enable leading-zero blanking when high; it is sampled every cycle.
REQ-008 Port digit  output  4  SHALL be the nibble for the active slot and feeds the hex-to-7-segment decoder.
REQ-009 Port blank  output  1  SHALL be high when no digit is lit, so downstream forces segments to 0000000.
REQ-010 Port an  output  4  SHALL be the active-low one-hot anode select, where an[i]=0 lights digit i.
REQ-011 Port frame_tick  output  1  SHALL be a one-cycle pulse at the end of each 4-slot frame.

Function
REQ-012 State SHALL consist of: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..3), pending register pend[15:0], and display register disp[15:0].
REQ-013 cnt SHALL increment each cycle and wrap from SCAN_DIV-1 to 0; on that wrap, idx SHALL increment modulo 4 (3 -> 0).
REQ-014 load=1 SHALL write value into pend; successive loads within a frame overwrite pend, and the last one wins.
REQ-015 At the frame boundary (the edge where idx goes 3 -> 0), disp SHALL take pend; if load=1 on that same edge, disp and pend SHALL both take value (bypass).
REQ-016 disp SHALL NOT change at any other time; a frame is never torn.
REQ-017 All outputs SHALL be registered or decoded solely from registered state, with no combinational path from inputs to outputs.
REQ-018 Sub-state BLANK SHALL hold when cnt < BLANK_CYC, and sub-state DRIVE when cnt >= BLANK_CYC; if BLANK_CYC=0, BLANK never occurs.
REQ-019 In BLANK: an=1111, blank=1, and digit holds disp nibble idx.
REQ-020 In DRIVE: an has bit idx low and all other bits high, blank=0, and digit=disp[4*idx+3:4*idx].
REQ-021 Leading-zero blanking SHALL apply when lz_en=1, idx >= 1, and every disp nibble at positions idx..3 is 0; the whole slot is then treated as BLANK (an=1111, blank=1).
REQ-022 Digit 0 SHALL never be leading-zero blanked, so value 0x0000 displays a single "0".
REQ-023 frame_tick SHALL be 1 exactly in the cycle where idx=3 and cnt=SCAN_DIV-1, and 0 otherwise; the period is 4*SCAN_DIV cycles.
REQ-024 A change of lz_en SHALL take effect in the next cycle; no frame alignment is applied to it.

Reset
REQ-025 While rst_n=0, regardless of clk: cnt=0, idx=0, pend=0, disp=0, digit=0000, blank=1, an=1111, frame_tick=0.
REQ-026 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately; load on a cycle in which rst_n=0 SHALL be ignored.
REQ-027 On the first rising edge after rst_n returns high, cnt SHALL go to 1 with idx=0; the first lit slot is digit 0, showing 0.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Reset: assert rst_n=0 at idx=2, cnt=5 -> in the same cycle an=1111, blank=1, digit=0, frame_tick=0; after release, slot 0 is lit at cnt=2 with digit=0.
REQ-029 Scan: load 0x1234, then observe the next full frame -> slot0: digit=4, an=1110 for cnt 2..7; slot1: 3/1101; slot2: 2/1011; slot3: 1/0111; an=1111 for cnt 0..1 of every slot.
REQ-030 Tear-free: with 0x1234 displayed, load 0xABCD at idx=2 -> slots 2 and 3 still show 2 and 1; the next frame shows D, C, B, A.
REQ-031 Boundary bypass: load 0x5A5A on the idx 3 -> 0 edge -> the new frame shows A, 5, A, 5 immediately.
REQ-032 Leading-zero blanking: lz_en=1, value 0x0050 -> slots 0 and 1 lit (0, 5), slots 2 and 3 blank=1, an=1111 for all 8 cycles; value 0x0000 -> only slot 0 lit.
REQ-033 frame_tick: over 96 cycles, exactly 3 pulses, each 1 cycle wide, at idx=3 and cnt=7, spaced 32 cycles apart.
